// File: rtl/accum_mask_pipe.sv
// accum_mask_pipe: accumulates ACC_LEN input beats into a WIDTH-bit window sum,
// then presents a registered masked result (sum + 1) & a_last together with a
// sticky overflow flag, held until the downstream handshake completes.
module accum_mask_pipe #(
  parameter int WIDTH   = 12,
  parameter int ACC_LEN = 4,
  parameter int SAT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam int                CW  = 8;
  localparam logic [CW-1:0]     LEN = CW'(ACC_LEN);
  localparam logic [WIDTH-1:0]  ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // WIDTH-bit add returning {carry, sum}; in clamp mode a carry forces all-ones.
  function automatic logic [WIDTH:0] add_w(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (SAT != 0 && s[WIDTH]) s[WIDTH-1:0] = '1;
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             first_beat;
  logic             beat;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   fin_w;
  logic             sticky_w;
  logic [CW-1:0]    count_w;

  assign in_ready   = en && rst && (state_q != HOLD);
  assign beat       = in_valid && in_ready;
  assign first_beat = (state_q == IDLE);

  // The first beat seeds from ~b & ~c; later beats add onto the running sum.
  assign op_x     = first_beat ? (~b & ~c) : acc_q;
  assign sum_w    = add_w(op_x, a | c);
  assign sticky_w = (!first_beat && sticky_q) || sum_w[WIDTH];
  assign fin_w    = add_w(sum_w[WIDTH-1:0], ONE);
  assign count_w  = first_beat ? 8'd1 : count_q + 8'd1;

  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign ovf       = ovf_q;

  // Next-state and datapath update for accept, last-beat capture and drain.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sticky_d    = sticky_q;
    f_d         = f_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          acc_d    = sum_w[WIDTH-1:0];
          count_d  = count_w;
          sticky_d = sticky_w;
          if (count_w == LEN) begin
            f_d         = fin_w[WIDTH-1:0] & a;
            ovf_d       = sticky_w || fin_w[WIDTH];
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers: synchronous active-low reset wins over en; en low freezes everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sticky_q    <= 1'b0;
      f_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sticky_q    <= sticky_d;
      f_q         <= f_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/accum_mask_pipe.md
ACCUM_MASK_PIPE -- requirements
Module: accum_mask_pipe

Interface
REQ-001 Parameter: WIDTH, default 12, data width of a, b, c and f; legal range 2..64.
REQ-002 Parameter: ACC_LEN, default 4, input beats per accumulation window; legal range 1..255.
REQ-003 Parameter: SAT, default 0, overflow mode; 0 = wrap modulo 2^WIDTH, 1 = clamp at 2^WIDTH-1.
REQ-004 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-low.
REQ-006 Port: en  input  1  global enable; low freezes all state.
REQ-007 Port: in_valid  input  1  input beat offered.
REQ-008 Port: in_ready  output  1  block accepts the beat this cycle.
REQ-009 Port: a  input  WIDTH  addend operand and output mask.
REQ-010 Port: b  input  WIDTH  seed operand (first beat only).
REQ-011 Port: c  input  WIDTH  seed and addend operand.
REQ-012 Port: out_valid  output  1  result f/ovf valid.
REQ-013 Port: out_ready  input  1  downstream accepts the result.
REQ-014 Port: f  output  WIDTH  registered window result.
REQ-015 Port: ovf  output  1  registered sticky overflow flag for the window.

Function
REQ-016 FSM states: IDLE, ACCUM, HOLD; a beat is accepted when in_valid && in_ready && en.
REQ-017 in_ready = 1 in IDLE and ACCUM when en = 1 and rst = 1; otherwise 0.
REQ-018 IDLE, beat accepted: acc <= (~b & ~c) + (a | c); beat count <= 1; sticky ovf cleared then updated by this add; next state ACCUM, or HOLD when ACC_LEN = 1.
REQ-019 ACCUM, beat accepted: acc <= acc + (a | c); count increments; b ignored.
REQ-020 The beat that brings count to ACC_LEN is the last beat; on that cycle f <= (acc_next + 1) & a_last, ovf <= sticky, out_valid <= 1; next state HOLD.
REQ-021 acc_next = the REQ-018/019 result of the last beat; a_last = a of the last beat.
REQ-022 Latency: f/out_valid visible one cycle after the last-beat edge.
REQ-023 Arithmetic: every add, including the +1, is WIDTH bits; any carry out of bit WIDTH-1 sets the sticky flag.
REQ-024 SAT = 0: add results wrap modulo 2^WIDTH.
REQ-025 SAT = 1: any carrying add yields all-ones; subsequent adds stay saturated.
REQ-026 HOLD: f, ovf and out_valid stay constant until out_valid && out_ready; no beats accepted.
REQ-027 HOLD, out_ready = 1: out_valid <= 0; next state IDLE.
REQ-028 Maximum throughput: one window per ACC_LEN+1 cycles.
REQ-029 en = 0: no state, counter, acc, f, ovf or out_valid change; a handshake on out_ready is not completed.
REQ-030 in_valid = 0 in ACCUM: acc and count hold; no timeout.

Reset
REQ-031 rst = 0 at a rising edge: state <= IDLE, acc <= 0, count <= 0, f <= 0, ovf <= 0, out_valid <= 0, regardless of en.
REQ-032 Reset mid-window or in HOLD discards partial and pending results; no output beat is produced for the aborted window.
REQ-033 in_ready = 0 during any cycle with rst = 0.

Verification (WIDTH=12, ACC_LEN=4 unless stated)
REQ-034 SAT=0, 4 back-to-back beats, a=0x0FF, b=0xFFF, c=0x000 -> acc 0x0FF, 0x1FE, 0x2FD, 0x3FC; next cycle f=0x0FD, ovf=0, out_valid=1.
REQ-035 SAT=1, 4 beats, a=0x001, b=0x000, c=0x000 -> first add clamps to 0xFFF; f=0x001, ovf=1.
REQ-036 SAT=0, same stimulus as REQ-035 -> acc 0x000, 0x001, 0x002, 0x003; f=0x000, ovf=1.
REQ-037 After REQ-034, out_ready=0 for 5 cycles with in_valid=1 -> f, ovf, out_valid stable, in_ready=0, no beat consumed; out_ready=1 -> IDLE next cycle, next window starts 1 cycle later.
REQ-038 Two beats accepted, then rst=0 for 1 cycle, then REQ-034 stimulus -> all outputs 0 during reset, result f=0x0FD, ovf=0.
REQ-039 en=0 for 3 cycles mid-window with in_valid=1 -> no beat accepted, acc unchanged; after en=1 the result equals the uninterrupted REQ-034 result.
